// File: rtl/vga_pixel_pipeline_if.sv
// Pixel-side bundle of vga_pixel_pipeline: source select/data in, frame-buffer address and DAC signals out.
// The testpat input exists only when VGA_TESTPAT_EN is defined.
interface vga_pixel_pipeline_if #(
  parameter int COLOR_WIDTH = 4,
  parameter int NUM_SRC     = 2,
  parameter int ADDR_W      = 19
);
  localparam int SEL_W = $clog2(NUM_SRC) + 1;

  logic [SEL_W-1:0]                 src_sel;
  logic [NUM_SRC*3*COLOR_WIDTH-1:0] src_data;
`ifdef VGA_TESTPAT_EN
  logic                             testpat;
`endif
  logic [ADDR_W-1:0]                fb_addr;
  logic [15:0]                      fb_x;
  logic [15:0]                      fb_y;
  logic [COLOR_WIDTH-1:0]           r_data;
  logic [COLOR_WIDTH-1:0]           g_data;
  logic [COLOR_WIDTH-1:0]           b_data;
  logic                             oHS;
  logic                             oVS;
  logic                             oBLANK_n;
  logic                             frame_start;
  logic [SEL_W-1:0]                 active_src;

  modport master (
`ifdef VGA_TESTPAT_EN
    input  testpat,
`endif
    input  src_sel, src_data,
    output fb_addr, fb_x, fb_y, r_data, g_data, b_data,
    output oHS, oVS, oBLANK_n, frame_start, active_src
  );

  modport slave (
`ifdef VGA_TESTPAT_EN
    output testpat,
`endif
    output src_sel, src_data,
    input  fb_addr, fb_x, fb_y, r_data, g_data, b_data,
    input  oHS, oVS, oBLANK_n, frame_start, active_src
  );
endinterface

// File: rtl/vga_pixel_pipeline.sv
// Parametrised VGA timing + scaled frame-buffer addressing + per-frame source mux with latency-matched sync/blank.
// Optional colour-bar test pattern is enabled by defining VGA_TESTPAT_EN.
module vga_pixel_pipeline #(
  parameter int COLOR_WIDTH = 4,
  parameter int H_ACTIVE    = 640,
  parameter int H_FP        = 16,
  parameter int H_SYNC      = 96,
  parameter int H_BP        = 48,
  parameter int V_ACTIVE    = 480,
  parameter int V_FP        = 10,
  parameter int V_SYNC      = 2,
  parameter int V_BP        = 33,
  parameter bit SYNC_POL    = 1'b0,
  parameter int SCALE_SHIFT = 2,
  parameter int NUM_SRC     = 2,
  parameter int RD_LAT      = 1,
  parameter int ADDR_W      = 19
) (
  input  logic                  iVGA_CLK,
  input  logic                  reset,
  vga_pixel_pipeline_if.master  vif
);
  localparam int CW       = COLOR_WIDTH;
  localparam int PIX_W    = 3 * CW;
  localparam int SEL_W    = $clog2(NUM_SRC) + 1;
  localparam int CNT_W    = 16;
  localparam int H_TOTAL  = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL  = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int HS_START = H_ACTIVE + H_FP;
  localparam int VS_START = V_ACTIVE + V_FP;
  localparam int FB_W     = H_ACTIVE >> SCALE_SHIFT;
  localparam int PIPE     = RD_LAT + 2;
  localparam int DL_N     = PIPE - 1;

  if (RD_LAT > 4 || NUM_SRC < 1 || (H_ACTIVE % (1 << SCALE_SHIFT)) != 0) begin : g_param_err
    $error("vga_pixel_pipeline: illegal parameter combination");
  end

  logic [CNT_W-1:0]  h_cnt_q, h_cnt_d, v_cnt_q, v_cnt_d;
  logic [15:0]       fb_x_q, fb_x_d, fb_y_q, fb_y_d;
  logic [ADDR_W-1:0] fb_addr_q, fb_addr_d;
  logic [31:0]       addr_full_s;
  logic              frame_start_q, frame_start_d;
  logic [SEL_W-1:0]  active_src_q, active_src_d;
  logic              active_s, hs_raw_s, vs_raw_s;
  logic [DL_N-1:0]   act_dl_q, act_dl_d, hs_dl_q, hs_dl_d, vs_dl_q, vs_dl_d;
  logic [PIX_W-1:0]  pix_s, rgb_q, rgb_d;
  logic              hs_q, hs_d, vs_q, vs_d, blank_n_q, blank_n_d;
`ifdef VGA_TESTPAT_EN
  localparam int BAR_W = H_ACTIVE / 8;
  logic              testpat_q, testpat_d;
  logic [2:0]        bar_s;
  logic [2:0]        bar_dl_q [DL_N];
  logic [2:0]        bar_dl_d [DL_N];
`endif

  // Timing counters, raw flags and registered frame-buffer address.
  always_comb begin
    h_cnt_d = h_cnt_q + 16'd1;
    v_cnt_d = v_cnt_q;
    if (h_cnt_q == CNT_W'(H_TOTAL - 1)) begin
      h_cnt_d = '0;
      if (v_cnt_q == CNT_W'(V_TOTAL - 1)) v_cnt_d = '0;
      else                                 v_cnt_d = v_cnt_q + 16'd1;
    end else begin
      v_cnt_d = v_cnt_q;
    end
    active_s = (h_cnt_q < CNT_W'(H_ACTIVE)) && (v_cnt_q < CNT_W'(V_ACTIVE));
    hs_raw_s = (h_cnt_q >= CNT_W'(HS_START)) && (h_cnt_q < CNT_W'(HS_START + H_SYNC));
    vs_raw_s = (v_cnt_q >= CNT_W'(VS_START)) && (v_cnt_q < CNT_W'(VS_START + V_SYNC));
    fb_x_d = h_cnt_q >> SCALE_SHIFT;
    fb_y_d = v_cnt_q >> SCALE_SHIFT;
    addr_full_s = 32'(fb_y_d) * 32'(FB_W) + 32'(fb_x_d);
    // Address freezes during blanking so the source sees a stable read.
    fb_addr_d = active_s ? addr_full_s[ADDR_W-1:0] : fb_addr_q;
    frame_start_d = (h_cnt_q == 16'd0) && (v_cnt_q == 16'd0);
    // Source selection only moves on the frame boundary, so a frame never tears.
    active_src_d = frame_start_d ? vif.src_sel : active_src_q;
  end

  // Sync/blank delay line and source mux feeding the output registers.
  always_comb begin
    act_dl_d[0] = active_s;
    hs_dl_d[0]  = hs_raw_s;
    vs_dl_d[0]  = vs_raw_s;
    for (int i = 1; i < DL_N; i++) begin
      act_dl_d[i] = act_dl_q[i-1];
      hs_dl_d[i]  = hs_dl_q[i-1];
      vs_dl_d[i]  = vs_dl_q[i-1];
    end
    pix_s = '0;
    for (int k = 0; k < NUM_SRC; k++) begin
      if (active_src_q == SEL_W'(k)) pix_s = vif.src_data[k*PIX_W +: PIX_W];
      else                           pix_s = pix_s;
    end
`ifdef VGA_TESTPAT_EN
    testpat_d = frame_start_d ? vif.testpat : testpat_q;
    bar_s = 3'(h_cnt_q / CNT_W'(BAR_W));
    bar_dl_d[0] = bar_s;
    for (int i = 1; i < DL_N; i++) bar_dl_d[i] = bar_dl_q[i-1];
    if (testpat_q) pix_s = {{CW{bar_dl_q[DL_N-1][2]}}, {CW{bar_dl_q[DL_N-1][1]}}, {CW{bar_dl_q[DL_N-1][0]}}};
    else           pix_s = pix_s;
`endif
    rgb_d     = act_dl_q[DL_N-1] ? pix_s : '0;
    hs_d      = hs_dl_q[DL_N-1] ? SYNC_POL : ~SYNC_POL;
    vs_d      = vs_dl_q[DL_N-1] ? SYNC_POL : ~SYNC_POL;
    blank_n_d = act_dl_q[DL_N-1];
  end

  // All state, asynchronously cleared.
  always_ff @(posedge iVGA_CLK or posedge reset) begin
    if (reset) begin
      h_cnt_q       <= '0;
      v_cnt_q       <= '0;
      fb_x_q        <= '0;
      fb_y_q        <= '0;
      fb_addr_q     <= '0;
      frame_start_q <= 1'b0;
      active_src_q  <= '0;
      act_dl_q      <= '0;
      hs_dl_q       <= '0;
      vs_dl_q       <= '0;
      rgb_q         <= '0;
      hs_q          <= ~SYNC_POL;
      vs_q          <= ~SYNC_POL;
      blank_n_q     <= 1'b0;
`ifdef VGA_TESTPAT_EN
      testpat_q     <= 1'b0;
      for (int i = 0; i < DL_N; i++) bar_dl_q[i] <= 3'd0;
`endif
    end else begin
      h_cnt_q       <= h_cnt_d;
      v_cnt_q       <= v_cnt_d;
      fb_x_q        <= fb_x_d;
      fb_y_q        <= fb_y_d;
      fb_addr_q     <= fb_addr_d;
      frame_start_q <= frame_start_d;
      active_src_q  <= active_src_d;
      act_dl_q      <= act_dl_d;
      hs_dl_q       <= hs_dl_d;
      vs_dl_q       <= vs_dl_d;
      rgb_q         <= rgb_d;
      hs_q          <= hs_d;
      vs_q          <= vs_d;
      blank_n_q     <= blank_n_d;
`ifdef VGA_TESTPAT_EN
      testpat_q     <= testpat_d;
      for (int i = 0; i < DL_N; i++) bar_dl_q[i] <= bar_dl_d[i];
`endif
    end
  end

  assign vif.fb_addr     = fb_addr_q;
  assign vif.fb_x        = fb_x_q;
  assign vif.fb_y        = fb_y_q;
  assign vif.r_data      = rgb_q[CW-1:0];
  assign vif.g_data      = rgb_q[2*CW-1:CW];
  assign vif.b_data      = rgb_q[3*CW-1:2*CW];
  assign vif.oHS         = hs_q;
  assign vif.oVS         = vs_q;
  assign vif.oBLANK_n    = blank_n_q;
  assign vif.frame_start = frame_start_q;
  assign vif.active_src  = active_src_q;
endmodule

// File: tb/tb_vga_pixel_pipeline.sv
// Directed bench on a shrunken 40x20 raster (32x16 active, 4x scaling, RD_LAT=3).
// Cycle n after reset release holds counter (n%40, (n/40)%20); outputs for it land at n+1 (address) / n+5 (pixel).
module tb_vga_pixel_pipeline;
  localparam int ADDR_W = 19;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc = 0;
  int   n_vec = 0;
  int   n_err = 0;
  logic [ADDR_W-1:0] lat_q [3];

  vga_pixel_pipeline_if #(.COLOR_WIDTH(4), .NUM_SRC(2), .ADDR_W(ADDR_W)) vif ();

  vga_pixel_pipeline #(
    .COLOR_WIDTH(4), .H_ACTIVE(32), .H_FP(2), .H_SYNC(4), .H_BP(2),
    .V_ACTIVE(16), .V_FP(1), .V_SYNC(2), .V_BP(1), .SYNC_POL(1'b0),
    .SCALE_SHIFT(2), .NUM_SRC(2), .RD_LAT(3), .ADDR_W(ADDR_W)
  ) dut (
    .iVGA_CLK (clk),
    .reset    (rst),
    .vif      (vif)
  );

  always #5 clk = ~clk;

  // Source memory with three cycles of read latency; colour encodes the address.
  always @(posedge clk) begin
    lat_q[0] <= vif.fb_addr;
    lat_q[1] <= lat_q[0];
    lat_q[2] <= lat_q[1];
  end
  assign vif.src_data = {4'hC, 4'h5, lat_q[2][3:0], 4'h0, lat_q[2][7:4], lat_q[2][3:0]};

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic goto(input int n);
    while (cyc < n) begin
      @(negedge clk);
      cyc++;
    end
  endtask

  function automatic logic [31:0] rgb_now();
    return {20'd0, vif.b_data, vif.g_data, vif.r_data};
  endfunction

  initial begin
    int lows;
`ifdef VGA_TESTPAT_EN
    vif.testpat = 1'b0;
`endif
    vif.src_sel = 2'd0;
    repeat (3) @(negedge clk);
    chk("rst_fb_addr", 32'(vif.fb_addr), 32'd0);
    chk("rst_frame_start", 32'(vif.frame_start), 32'd0);
    chk("rst_active_src", 32'(vif.active_src), 32'd0);
    chk("rst_hs", 32'(vif.oHS), 32'd1);
    chk("rst_vs", 32'(vif.oVS), 32'd1);
    chk("rst_blank_n", 32'(vif.oBLANK_n), 32'd0);
    chk("rst_rgb", rgb_now(), 32'd0);
    rst = 1'b0;
    cyc = 0;

    goto(1);   chk("fs_first", 32'(vif.frame_start), 32'd1);
    goto(2);   chk("fs_drop", 32'(vif.frame_start), 32'd0);
    goto(38);  chk("hs_pre", 32'(vif.oHS), 32'd1);
    goto(39);  chk("hs_start", 32'(vif.oHS), 32'd0);
    goto(42);  chk("hs_last", 32'(vif.oHS), 32'd0);
    goto(43);  chk("hs_end", 32'(vif.oHS), 32'd1);
    lows = 0;
    for (int i = 0; i < 40; i++) begin
      goto(45 + i);
      if (vif.oHS === 1'b0) lows++;
    end
    chk("hs_low_per_line", 32'(lows), 32'd4);

    goto(164); chk("blank_before_line", 32'(vif.oBLANK_n), 32'd0);
               chk("rgb_before_line", rgb_now(), 32'd0);
    goto(165); chk("blank_first_pix", 32'(vif.oBLANK_n), 32'd1);
               chk("rgb_first_pix", rgb_now(), 32'h008);
    goto(197); chk("blank_after_line", 32'(vif.oBLANK_n), 32'd0);
               chk("rgb_forced_black", rgb_now(), 32'd0);

    goto(366); chk("fb_x_5_9", 32'(vif.fb_x), 32'd1);
               chk("fb_y_5_9", 32'(vif.fb_y), 32'd2);
               chk("fb_addr_5_9", 32'(vif.fb_addr), 32'd17);
    goto(370); chk("rgb_5_9", rgb_now(), 32'h011);
               chk("blank_5_9", 32'(vif.oBLANK_n), 32'd1);

    goto(400); vif.src_sel = 2'd1;
    goto(489); chk("rgb_no_tear", rgb_now(), 32'h019);
    goto(500); chk("src_held", 32'(vif.active_src), 32'd0);

    goto(684); chk("vs_pre", 32'(vif.oVS), 32'd1);
    goto(685); chk("vs_start", 32'(vif.oVS), 32'd0);
    goto(764); chk("vs_last", 32'(vif.oVS), 32'd0);
    goto(765); chk("vs_end", 32'(vif.oVS), 32'd1);

    goto(800); chk("fs_not_early", 32'(vif.frame_start), 32'd0);
    goto(801); chk("fs_period", 32'(vif.frame_start), 32'd1);
               chk("src_switch", 32'(vif.active_src), 32'd1);
    goto(805); chk("rgb_src1_first", rgb_now(), 32'hC50);

    goto(1200); vif.src_sel = 2'd3;
    goto(1601); chk("fs_frame2", 32'(vif.frame_start), 32'd1);
                chk("src_invalid", 32'(vif.active_src), 32'd3);
    goto(1639); chk("hs_with_black", 32'(vif.oHS), 32'd0);
    goto(1970); chk("rgb_black_src", rgb_now(), 32'd0);
                chk("blank_black_src", 32'(vif.oBLANK_n), 32'd1);

    goto(1850); chk("blank_pre_rst", 32'(vif.oBLANK_n), 32'd1);
    rst = 1'b1;
    #1;
    chk("mid_rst_fb_addr", 32'(vif.fb_addr), 32'd0);
    chk("mid_rst_fb_y", 32'(vif.fb_y), 32'd0);
    chk("mid_rst_active_src", 32'(vif.active_src), 32'd0);
    chk("mid_rst_blank_n", 32'(vif.oBLANK_n), 32'd0);
    chk("mid_rst_hs", 32'(vif.oHS), 32'd1);
    chk("mid_rst_vs", 32'(vif.oVS), 32'd1);
    vif.src_sel = 2'd1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    cyc = 0;

    goto(1);   chk("post_rst_fs", 32'(vif.frame_start), 32'd1);
               chk("post_rst_src", 32'(vif.active_src), 32'd1);
               chk("post_rst_fb_x", 32'(vif.fb_x), 32'd0);
               chk("post_rst_fb_y", 32'(vif.fb_y), 32'd0);
    goto(21);  chk("post_rst_fb_x20", 32'(vif.fb_x), 32'd5);
    goto(161); chk("post_rst_fb_y4", 32'(vif.fb_y), 32'd1);
               chk("post_rst_addr", 32'(vif.fb_addr), 32'd8);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
